rx_word_align: RTL

Word-alignment controller for one serial receive lane. It sits directly downstream of the 1:12 ISERDES deserializer. It watches the 12-bit parallel word for a fixed training pattern and drives the deserializer's bitslip and IDELAY load controls until the pattern is received on the correct word boundary. It then passes aligned words downstream with a valid flag. It runs in the deserializer's slow word-clock domain.

---
 rtl/rx_word_align.sv | 191 +++++++++++++++++++
 1 files changed

// File: rtl/rx_word_align.sv
// rx_word_align
//
// Word-alignment controller for one serial receive lane, placed directly after
// a 1:12 deserializer and clocked by its word clock. While aligning it looks for
// TRAIN_PATTERN on the registered parallel word. On a miss it pulses bitslip to
// try the next of the 12 bit positions. After all 12 positions have failed it
// advances the IDELAY tap by DLY_STEP and starts over. It declares lock after
// MATCH_CNT consecutive matches. It flags an error once the tap range is used up.
//
// Ports
//   clk_rxg         in   word clock (line rate / 12), sole clock
//   rst_rx          in   asynchronous active-high reset
//   align_en        in   level: high runs/holds alignment, low aborts to idle
//   data_in         in   12-bit parallel word from the deserializer
//   bitslip         out  one-cycle bitslip request to the deserializer
//   idelay_ld       out  one-cycle IDELAY load strobe
//   idelay_valuein  out  IDELAY tap value, stable while idelay_ld is high
//   aligned         out  lock achieved
//   align_err       out  whole tap/bit sweep exhausted without lock
//   word_out        out  data_in delayed by one cycle
//   word_valid      out  same as aligned, co-timed with word_out
//
// State table
//   state      | meaning
//   S_IDLE     | alignment disabled; tap and slip position reset
//   S_LOAD_DLY | idelay_ld strobe cycle for the current tap
//   S_SETTLE   | wait SETTLE_CYC cycles for slip/delay to reach data_r
//   S_CHECK    | compare data_r against TRAIN_PATTERN each cycle
//   S_SLIP     | bitslip pulse cycle, advance bit position
//   S_LOCKED   | aligned; live data flows, mismatches ignored
//   S_FAIL     | sweep exhausted; align_err held until align_en drops

module rx_word_align #(
  parameter logic [11:0] TRAIN_PATTERN = 12'hFC0,
  parameter int          MATCH_CNT     = 16,
  parameter int          SETTLE_CYC    = 8,
  parameter int          DLY_STEP      = 4
) (
  input  logic        clk_rxg,
  input  logic        rst_rx,
  input  logic        align_en,
  input  logic [11:0] data_in,
  output logic        bitslip,
  output logic        idelay_ld,
  output logic [4:0]  idelay_valuein,
  output logic        aligned,
  output logic        align_err,
  output logic [11:0] word_out,
  output logic        word_valid
);

  // Settle timer is a down-counter loaded with SETTLE_CYC-1 and left on zero,
  // which gives exactly SETTLE_CYC cycles in S_SETTLE.
  localparam logic [3:0] SETTLE_LOAD = 4'(SETTLE_CYC - 1);
  localparam logic [7:0] MATCH_LAST  = 8'(MATCH_CNT - 1);
  localparam logic [3:0] SLIP_LAST   = 4'd11;
  localparam logic [5:0] STEP_W      = 6'(DLY_STEP);
  localparam logic [5:0] TAP_MAX     = 6'd31;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD_DLY,
    S_SETTLE,
    S_CHECK,
    S_SLIP,
    S_LOCKED,
    S_FAIL
  } state_t;

  state_t      state;
  logic [11:0] data_r;
  logic [3:0]  settle_cnt;
  logic [7:0]  match_cnt;
  logic [3:0]  slip_cnt;
  logic [4:0]  dly_tap;

  logic [5:0]  next_tap;
  logic        tap_room;
  logic        pat_hit;

  // Tap advance is evaluated one bit wider so the last step cannot wrap to 0.
  assign next_tap = {1'b0, dly_tap} + STEP_W;
  assign tap_room = (next_tap <= TAP_MAX);
  assign pat_hit  = (data_r == TRAIN_PATTERN);

  always_ff @(posedge clk_rxg or posedge rst_rx) begin
    if (rst_rx) begin
      data_r <= 12'd0;
    end else begin
      data_r <= data_in;
    end
  end

  assign word_out   = data_r;
  assign word_valid = aligned;

  always_ff @(posedge clk_rxg or posedge rst_rx) begin
    if (rst_rx) begin
      state          <= S_IDLE;
      settle_cnt     <= 4'd0;
      match_cnt      <= 8'd0;
      slip_cnt       <= 4'd0;
      dly_tap        <= 5'd0;
      bitslip        <= 1'b0;
      idelay_ld      <= 1'b0;
      idelay_valuein <= 5'd0;
      aligned        <= 1'b0;
      align_err      <= 1'b0;
    end else begin
      // Strobes are single-cycle by construction: they drop on every edge
      // unless the transition below re-asserts them.
      bitslip   <= 1'b0;
      idelay_ld <= 1'b0;

      if (!align_en) begin
        state     <= S_IDLE;
        aligned   <= 1'b0;
        align_err <= 1'b0;
        dly_tap   <= 5'd0;
        slip_cnt  <= 4'd0;
      end else begin
        case (state)
          S_IDLE: begin
            dly_tap        <= 5'd0;
            slip_cnt       <= 4'd0;
            idelay_valuein <= 5'd0;
            idelay_ld      <= 1'b1;
            state          <= S_LOAD_DLY;
          end

          S_LOAD_DLY: begin
            slip_cnt   <= 4'd0;
            settle_cnt <= SETTLE_LOAD;
            state      <= S_SETTLE;
          end

          S_SETTLE: begin
            if (settle_cnt == 4'd0) begin
              match_cnt <= 8'd0;
              state     <= S_CHECK;
            end else begin
              settle_cnt <= settle_cnt - 4'd1;
            end
          end

          S_CHECK: begin
            if (pat_hit) begin
              match_cnt <= match_cnt + 8'd1;
              if (match_cnt == MATCH_LAST) begin
                aligned <= 1'b1;
                state   <= S_LOCKED;
              end
            end else if (slip_cnt < SLIP_LAST) begin
              bitslip <= 1'b1;
              state   <= S_SLIP;
            end else if (tap_room) begin
              // Value and strobe go out together so the tap is stable
              // for the whole idelay_ld cycle.
              dly_tap        <= next_tap[4:0];
              idelay_valuein <= next_tap[4:0];
              idelay_ld      <= 1'b1;
              state          <= S_LOAD_DLY;
            end else begin
              align_err <= 1'b1;
              state     <= S_FAIL;
            end
          end

          S_SLIP: begin
            slip_cnt   <= slip_cnt + 4'd1;
            settle_cnt <= SETTLE_LOAD;
            state      <= S_SETTLE;
          end

          S_LOCKED: begin
            state <= S_LOCKED;
          end

          S_FAIL: begin
            state <= S_FAIL;
          end

          default: begin
            state <= S_IDLE;
          end
        endcase
      end
    end
  end

endmodule
